// File: rtl/intr_handler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : intr_handler_pkg
//  Brief    : Shared state encoding and output codes for the interrupt handler
//  Revision : 1.0
// ============================================================================
package intr_handler_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    WAIT   = 3'b001,
    ENIN   = 3'b010,
    ENIN_W = 3'b011,
    INTR   = 3'b100,
    INTR_1 = 3'b101,
    INTR_W = 3'b110
  } state_t;

  localparam logic [2:1] c_cc_idle  = 2'b01;
  localparam logic [2:1] c_cc_intr  = 2'b10;
  localparam logic [2:1] c_cc_serve = 2'b11;

  localparam logic [2:1] c_us_serve = 2'b00;
  localparam logic [2:1] c_us_idle  = 2'b01;
  localparam logic [2:1] c_us_intr  = 2'b11;

  // Index following idx in a ring of nch channels.
  function automatic int next_index(input int idx, input int nch);
    return (idx + 1 >= nch) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intr_handler_if.sv
`default_nettype none
// ============================================================================
//  Module   : intr_handler_if
//  Brief    : Request/status bundle between peripherals and the handler
//  Revision : 1.0
// ============================================================================
interface intr_handler_if #(
  parameter int NCH = 4
);
  localparam int IDW = $clog2(NCH);

  logic [NCH-1:0] eql;
  logic           cont_eql;
  logic [2:1]     cc_mux;
  logic [2:1]     uscite;
  logic           enable_count;
  logic           ackout;
  logic [NCH-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic           timeout;

  modport master (
    output eql, cont_eql,
    input  cc_mux, uscite, enable_count, ackout, grant, grant_id, timeout
  );

  modport slave (
    input  eql, cont_eql,
    output cc_mux, uscite, enable_count, ackout, grant, grant_id, timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin search starting at i_rr_ptr
//  Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int IDW = $clog2(NCH)
) (
  input  wire logic [NCH-1:0] i_req,
  input  wire logic [IDW-1:0] i_rr_ptr,
  output logic      [NCH-1:0] o_onehot,
  output logic      [IDW-1:0] o_index
);

  logic [IDW:0] w_k;
  logic         w_found;

  always_comb begin
    o_onehot = '0;
    o_index  = '0;
    w_found  = 1'b0;
    w_k      = '0;
    for (int i = 0; i < NCH; i++) begin
      // One extra bit so the wrap test works for non power-of-two NCH.
      w_k = {1'b0, i_rr_ptr} + (IDW+1)'(i);
      if (w_k >= (IDW+1)'(NCH)) begin
        w_k = w_k - (IDW+1)'(NCH);
      end
      if (!w_found && i_req[w_k[IDW-1:0]]) begin
        w_found                     = 1'b1;
        o_onehot[w_k[IDW-1:0]]      = 1'b1;
        o_index                     = w_k[IDW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/intr_handler_n.sv
`default_nettype none
// ============================================================================
//  Module   : intr_handler_n
//  Brief    : NCH-channel interrupt handshake FSM with round-robin grant,
//             dwell limit and timeout pulse
//  Revision : 1.0
// ============================================================================
module intr_handler_n
  import intr_handler_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int MAX_DWELL = 8
) (
  input wire logic        clock,
  input wire logic        reset,
  intr_handler_if.slave   bus
);

  localparam int IDW = $clog2(NCH);
  localparam int DW  = $clog2(MAX_DWELL);
  localparam logic [DW-1:0] c_dwell_last = DW'(MAX_DWELL - 1);

  state_t         r_state,        w_state_next;
  logic [2:1]     r_cc_mux,       w_cc_mux;
  logic [2:1]     r_uscite,       w_uscite;
  logic           r_enable_count, w_enable_count;
  logic           r_ackout,       w_ackout;
  logic [NCH-1:0] r_grant,        w_grant;
  logic [IDW-1:0] r_grant_id,     w_grant_id;
  logic           r_timeout,      w_timeout;
  logic [IDW-1:0] r_rr_ptr,       w_rr_ptr;
  logic [DW-1:0]  r_dwell,        w_dwell;

  logic [NCH-1:0] w_pick_onehot;
  logic [IDW-1:0] w_pick_index;
  logic           w_any;
  logic           w_req;
  logic           w_expiry;

  rr_arbiter #(
    .NCH (NCH)
  ) u_rr_arbiter (
    .i_req    (bus.eql),
    .i_rr_ptr (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_index)
  );

  assign w_any    = |bus.eql;
  assign w_req    = bus.eql[r_grant_id];
  assign w_expiry = w_req && (r_dwell == c_dwell_last);

  always_comb begin
    w_state_next   = r_state;
    w_cc_mux       = r_cc_mux;
    w_uscite       = r_uscite;
    w_ackout       = ~bus.cont_eql;
    w_enable_count = ~bus.cont_eql;
    w_grant        = r_grant;
    w_grant_id     = r_grant_id;
    w_timeout      = 1'b0;
    w_rr_ptr       = r_rr_ptr;
    w_dwell        = r_dwell;

    case (r_state)
      INIT: begin
        w_state_next = WAIT;
        w_uscite     = c_us_idle;
        w_cc_mux     = c_cc_idle;
      end
      WAIT, INTR_1: begin
        if (w_any) begin
          w_state_next = (r_state == WAIT) ? ENIN : INTR;
          w_uscite     = c_us_serve;
          w_cc_mux     = c_cc_serve;
          w_grant      = w_pick_onehot;
          w_grant_id   = w_pick_index;
          w_dwell      = '0;
        end else begin
          w_state_next = (r_state == WAIT) ? INTR_1 : WAIT;
          w_uscite     = c_us_idle;
          w_cc_mux     = (r_state == WAIT) ? c_cc_intr : c_cc_idle;
        end
      end
      ENIN, INTR: begin
        if (w_req && !w_expiry) begin
          w_uscite = c_us_serve;
          w_cc_mux = c_cc_serve;
          w_dwell  = r_dwell + DW'(1);
        end else begin
          w_timeout = w_expiry;
          if (r_state == ENIN) begin
            // The ENIN exit acknowledges regardless of cont_eql.
            w_state_next   = ENIN_W;
            w_uscite       = c_us_idle;
            w_cc_mux       = c_cc_idle;
            w_ackout       = 1'b1;
            w_enable_count = 1'b1;
          end else begin
            w_state_next = INTR_W;
            w_uscite     = c_us_intr;
            w_cc_mux     = c_cc_intr;
          end
        end
      end
      ENIN_W, INTR_W: begin
        if (w_req) begin
          w_uscite = (r_state == ENIN_W) ? c_us_idle : c_us_intr;
          w_cc_mux = (r_state == ENIN_W) ? c_cc_idle : c_cc_intr;
        end else begin
          w_state_next = WAIT;
          w_uscite     = c_us_idle;
          w_cc_mux     = c_cc_idle;
          w_grant      = '0;
          w_grant_id   = '0;
          w_rr_ptr     = IDW'(next_index(int'(r_grant_id), NCH));
        end
      end
      default: begin
        w_state_next   = INIT;
        w_ackout       = r_ackout;
        w_enable_count = r_enable_count;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= INIT;
      r_cc_mux       <= c_cc_idle;
      r_uscite       <= c_us_serve;
      r_enable_count <= 1'b0;
      r_ackout       <= 1'b0;
      r_grant        <= '0;
      r_grant_id     <= '0;
      r_timeout      <= 1'b0;
      r_rr_ptr       <= '0;
      r_dwell        <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cc_mux       <= w_cc_mux;
      r_uscite       <= w_uscite;
      r_enable_count <= w_enable_count;
      r_ackout       <= w_ackout;
      r_grant        <= w_grant;
      r_grant_id     <= w_grant_id;
      r_timeout      <= w_timeout;
      r_rr_ptr       <= w_rr_ptr;
      r_dwell        <= w_dwell;
    end
  end

  assign bus.cc_mux       = r_cc_mux;
  assign bus.uscite       = r_uscite;
  assign bus.enable_count = r_enable_count;
  assign bus.ackout       = r_ackout;
  assign bus.grant        = r_grant;
  assign bus.grant_id     = r_grant_id;
  assign bus.timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_intr_handler_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intr_handler_n
//  Brief    : Directed self-checking bench for intr_handler_n (NCH=4, dwell 8)
//  Revision : 1.0
// ============================================================================
module tb_intr_handler_n;
  import intr_handler_pkg::*;

  localparam int NCH       = 4;
  localparam int MAX_DWELL = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  intr_handler_if #(.NCH(NCH)) bus ();

  intr_handler_n #(
    .NCH       (NCH),
    .MAX_DWELL (MAX_DWELL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    int n_enin;
    int n_to;
    order = '{0, 1, 2, 3, 0};

    bus.eql      = '0;
    bus.cont_eql = 1'b1;
    reset        = 1'b1;
    tick();
    tick();
    chk("rst_state",  32'(dut.r_state),        32'(INIT));
    chk("rst_cc",     32'(bus.cc_mux),         32'h1);
    chk("rst_us",     32'(bus.uscite),         32'h0);
    chk("rst_ack",    32'(bus.ackout),         32'h0);
    chk("rst_en",     32'(bus.enable_count),   32'h0);
    chk("rst_grant",  32'(bus.grant),          32'h0);
    chk("rst_gid",    32'(bus.grant_id),       32'h0);
    chk("rst_to",     32'(bus.timeout),        32'h0);

    // Idle walk after reset: INIT -> WAIT -> INTR_1 -> WAIT
    reset = 1'b0;
    tick();
    chk("idle1_state", 32'(dut.r_state), 32'(WAIT));
    chk("idle1_us",    32'(bus.uscite),  32'h1);
    chk("idle1_cc",    32'(bus.cc_mux),  32'h1);
    tick();
    chk("idle2_state", 32'(dut.r_state), 32'(INTR_1));
    chk("idle2_us",    32'(bus.uscite),  32'h1);
    chk("idle2_cc",    32'(bus.cc_mux),  32'h2);
    chk("idle2_grant", 32'(bus.grant),   32'h0);
    tick();
    chk("idle3_state", 32'(dut.r_state), 32'(WAIT));
    chk("idle3_us",    32'(bus.uscite),  32'h1);
    chk("idle3_cc",    32'(bus.cc_mux),  32'h1);

    // Single ENIN service on channel 2
    bus.eql = 4'b0100;
    tick();
    chk("enin_state", 32'(dut.r_state),  32'(ENIN));
    chk("enin_grant", 32'(bus.grant),    32'h4);
    chk("enin_gid",   32'(bus.grant_id), 32'h2);
    chk("enin_us",    32'(bus.uscite),   32'h0);
    chk("enin_cc",    32'(bus.cc_mux),   32'h3);
    chk("enin_ack",   32'(bus.ackout),   32'h0);
    tick();
    tick();
    chk("enin_hold", 32'(dut.r_state), 32'(ENIN));
    bus.eql = '0;
    tick();
    chk("eninw_state", 32'(dut.r_state),      32'(ENIN_W));
    chk("eninw_ack",   32'(bus.ackout),       32'h1);
    chk("eninw_en",    32'(bus.enable_count), 32'h1);
    chk("eninw_us",    32'(bus.uscite),       32'h1);
    chk("eninw_cc",    32'(bus.cc_mux),       32'h1);
    chk("eninw_to",    32'(bus.timeout),      32'h0);
    tick();
    chk("rel_state", 32'(dut.r_state),  32'(WAIT));
    chk("rel_grant", 32'(bus.grant),    32'h0);
    chk("rel_gid",   32'(bus.grant_id), 32'h0);
    chk("rel_ptr",   32'(dut.r_rr_ptr), 32'h3);
    chk("rel_ack",   32'(bus.ackout),   32'h0);

    // INTR path on channel 1, cont_eql low while serving
    tick();
    chk("intr1_state", 32'(dut.r_state), 32'(INTR_1));
    bus.eql      = 4'b0010;
    bus.cont_eql = 1'b0;
    tick();
    chk("intr_state", 32'(dut.r_state),      32'(INTR));
    chk("intr_us",    32'(bus.uscite),       32'h0);
    chk("intr_cc",    32'(bus.cc_mux),       32'h3);
    chk("intr_grant", 32'(bus.grant),        32'h2);
    chk("intr_gid",   32'(bus.grant_id),     32'h1);
    chk("intr_ack",   32'(bus.ackout),       32'h1);
    chk("intr_en",    32'(bus.enable_count), 32'h1);
    tick();
    chk("intr_hold", 32'(dut.r_state), 32'(INTR));
    bus.eql      = '0;
    bus.cont_eql = 1'b1;
    tick();
    chk("intrw_state", 32'(dut.r_state), 32'(INTR_W));
    chk("intrw_us",    32'(bus.uscite),  32'h3);
    chk("intrw_cc",    32'(bus.cc_mux),  32'h2);
    chk("intrw_ack",   32'(bus.ackout),  32'h0);
    tick();
    chk("intrrel_state", 32'(dut.r_state),  32'(WAIT));
    chk("intrrel_us",    32'(bus.uscite),   32'h1);
    chk("intrrel_cc",    32'(bus.cc_mux),   32'h1);
    chk("intrrel_grant", 32'(bus.grant),    32'h0);
    chk("intrrel_to",    32'(bus.timeout),  32'h0);
    chk("intrrel_ptr",   32'(dut.r_rr_ptr), 32'h2);

    // Reset while in ENIN_W holding channel 3
    bus.eql = 4'b1000;
    tick();
    chk("c3_state", 32'(dut.r_state),  32'(ENIN));
    chk("c3_gid",   32'(bus.grant_id), 32'h3);
    bus.eql = '0;
    tick();
    chk("c3w_state", 32'(dut.r_state), 32'(ENIN_W));
    chk("c3w_grant", 32'(bus.grant),   32'h8);
    reset   = 1'b1;
    bus.eql = 4'b1000;
    tick();
    chk("mrst_state", 32'(dut.r_state),  32'(INIT));
    chk("mrst_grant", 32'(bus.grant),    32'h0);
    chk("mrst_cc",    32'(bus.cc_mux),   32'h1);
    chk("mrst_us",    32'(bus.uscite),   32'h0);
    chk("mrst_ack",   32'(bus.ackout),   32'h0);
    chk("mrst_ptr",   32'(dut.r_rr_ptr), 32'h0);
    reset = 1'b0;
    tick();
    chk("mrst_wait", 32'(dut.r_state), 32'(WAIT));
    tick();
    chk("mrst_regrant", 32'(bus.grant),    32'h8);
    chk("mrst_regid",   32'(bus.grant_id), 32'h3);
    bus.eql = '0;
    tick();
    tick();
    chk("mrst_rel_ptr", 32'(dut.r_rr_ptr), 32'h0);

    // All channels requesting: rotation and dwell expiry per grant
    bus.eql = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gid",   32'(bus.grant_id), 32'(order[g]));
      chk("rr_grant", 32'(bus.grant),    32'(4'b0001 << order[g]));
      n_enin = 1;
      n_to   = int'(bus.timeout);
      for (int c = 0; c < 20; c++) begin
        tick();
        n_to += int'(bus.timeout);
        if (dut.r_state != ENIN) break;
        n_enin++;
      end
      chk("rr_enin_cycles", 32'(n_enin),       32'(MAX_DWELL));
      chk("rr_exit_state",  32'(dut.r_state),  32'(ENIN_W));
      chk("rr_exit_to",     32'(bus.timeout),  32'h1);
      bus.eql = 4'b1111 & ~(4'b0001 << order[g]);
      tick();
      n_to += int'(bus.timeout);
      chk("rr_back_wait", 32'(dut.r_state), 32'(WAIT));
      chk("rr_to_pulses", 32'(n_to),        32'h1);
      bus.eql = 4'b1111;
    end

    // Illegal state encoding recovers through INIT with outputs held
    bus.eql = '0;
    tick();
    chk("ill_pre_state", 32'(dut.r_state), 32'(INTR_1));
    bus.eql = 4'b0001;
    tick();
    chk("ill_pre_gid", 32'(bus.grant_id), 32'h0);
    bus.eql = '0;
    tick();
    chk("ill_pre_intrw", 32'(dut.r_state), 32'(INTR_W));
    force dut.r_state = state_t'(3'b111);
    #1;
    chk("ill_next", 32'(dut.w_state_next), 32'(INIT));
    tick();
    chk("ill_hold_cc",    32'(bus.cc_mux), 32'h2);
    chk("ill_hold_us",    32'(bus.uscite), 32'h3);
    chk("ill_hold_grant", 32'(bus.grant),  32'h1);
    force dut.r_state = INIT;
    #1;
    chk("ill_then_wait", 32'(dut.w_state_next), 32'(WAIT));
    release dut.r_state;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("final_wait", 32'(dut.r_state), 32'(WAIT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intr_handler_n.md
# intr_handler_n

Parametrised multi-channel interrupt handler. It generalises the single-request `eql` handshake FSM to NCH request channels with round-robin arbitration, per-grant dwell limiting, and a timeout flag. It sits between the peripheral request lines and the count/mux datapath, and drives `cc_mux`, `uscite`, `enable_count` and `ackout` with the established encodings.

## Interface
- NCH, 4: number of request channels, 2..16
- MAX_DWELL, 8: max cycles a grant may remain in ENIN or INTR, ≥2
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- eql  input  NCH  per-channel request level
- cont_eql  input  1  global continue/hold; 1 clears ackout/enable_count
- cc_mux  output  [2:1]  count mux select
- uscite  output  [2:1]  status code
- enable_count  output  1  counter enable
- ackout  output  1  acknowledge
- grant  output  NCH  one-hot served channel, 0 when idle
- grant_id  output  $clog2(NCH)  index of served channel, 0 when idle
- timeout  output  1  one-cycle pulse on forced dwell release

## Operation
- All outputs are registered. Reset values: state=INIT, cc_mux=01, uscite=00, enable_count=0, ackout=0, grant=0, grant_id=0, timeout=0, rr_ptr=0, dwell=0.
- Each non-reset cycle: cont_eql=1 → ackout=0, enable_count=0; cont_eql=0 → both 1. The ENIN exit row below overrides this to 1.
- `any` = |eql. `pick` = first set index searching rr_ptr, rr_ptr+1, … mod NCH. `req` = eql[sel], where sel is the latched grant index.
- States and transitions, given as condition → uscite/cc_mux, next state:
  - INIT → 01/01, WAIT.
  - WAIT: any → 00/11, ENIN; sel=pick; grant set. Otherwise → 01/10, INTR_1.
  - INTR_1: any → 00/11, INTR; sel=pick; grant set. Otherwise → 01/01, WAIT.
  - ENIN: req and no expiry → 00/11, stay. Otherwise → 01/01, ackout=1, enable_count=1, ENIN_W.
  - ENIN_W: req → 01/01, stay. Otherwise → 01/01, WAIT; release.
  - INTR: req and no expiry → 00/11, stay. Otherwise → 11/10, INTR_W.
  - INTR_W: req → 11/10, stay. Otherwise → 01/01, WAIT; release.
  - Any illegal encoding → INIT, with other outputs held.
- Release: grant=0, grant_id=0, rr_ptr=(sel+1) mod NCH.
- Dwell: cleared on entry to ENIN or INTR, incremented each cycle the state holds.
  - Expiry = req held and dwell==MAX_DWELL-1. Expiry takes the "otherwise" exit and pulses timeout=1 for that cycle.
  - Dwell width is $clog2(MAX_DWELL). The counter never wraps.
- Only eql[sel] is observed while granted. Other channels' requests are ignored until release and are never lost: they are level-sampled later.

## Timing
- One-cycle latency: state and outputs update on the edge after the inputs are sampled.
- Minimum service: WAIT → ENIN → ENIN_W → WAIT takes 3 cycles.
- A grant in ENIN or INTR lasts at most MAX_DWELL cycles. ENIN_W and INTR_W are unbounded while req is held.
- If several channels assert in the same cycle, pick selects one and the others wait. With continuous requests, every channel is served within NCH grants.
- Reset mid-grant: the next edge gives the reset values, with grant dropped and rr_ptr=0.
- cont_eql and the ENIN exit in the same cycle: the exit wins and ackout=1.

## Structure
- Package `intr_handler_pkg`:
  - state enum: INIT=000, WAIT=001, ENIN=010, ENIN_W=011, INTR=100, INTR_1=101, INTR_W=110
  - cc_mux/uscite code constants
- Sub-module `rr_arbiter`: combinational priority search, parameterised by NCH. Inputs are the request vector and rr_ptr. Outputs are a one-hot and an index.
- Top level: FSM, dwell counter, rr_ptr and output registers.

## Test plan
- Reset held 2 cycles, then released with eql=0 → INIT, WAIT, INTR_1, WAIT; uscite 01 each cycle; cc_mux 01, 10, 01; grant=0.
- In WAIT, eql=0100 for 3 cycles, then 0 → grant=0100, grant_id=2, uscite=00/cc_mux=11. On the drop cycle: ackout=1, enable_count=1 with cont_eql=1. Then WAIT, and rr_ptr=3.
- In WAIT, eql=1111 held continuously over successive grants → served order 0, 1, 2, 3, 0. Each ENIN lasts exactly 8 cycles, and timeout pulses once per grant.
- INTR path: in INTR_1, eql=0010 held 2 cycles, then 0 for 2 cycles → INTR 00/11, INTR_W 11/10, WAIT 01/01; timeout=0.
- Reset asserted while in ENIN_W with grant=1000 → the next cycle gives grant=0, cc_mux=01, uscite=00, ackout=0. After release, eql=1000 is served again with grant_id=3.
- State register forced to 111 → next state INIT, then WAIT.
